// File: rtl/prog_updown_counter_if.sv
// Control/status bundle for prog_updown_counter: the host drives the count
// controls and observes the registered count and flags.
interface prog_updown_counter_if #(
  parameter int WIDTH = 4
) ();
  logic             en;
  logic             up;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             flag_clr;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;
  logic             unf;

  modport master (
    output en, up, clear, load, load_val, flag_clr,
    input  q, tc, ovf, unf
  );

  modport slave (
    input  en, up, clear, load, load_val, flag_clr,
    output q, tc, ovf, unf
  );
endinterface

// File: rtl/prog_updown_counter.sv
// Programmable-modulus up/down counter with enable prescaler, parallel load,
// wrap/saturate boundary handling, terminal-count pulse and sticky flags.
module prog_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 15,
  parameter int PRESCALE  = 1,
  parameter int SATURATE  = 0
) (
  input logic                 clk,
  input logic                 reset,
  prog_updown_counter_if.slave bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MAX_COUNT);
  localparam logic [PW-1:0]    PLAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] q, qNext;
  logic [PW-1:0]    phase, phaseNext;
  logic             tc, tcNext;
  logic             ovf, ovfNext;
  logic             unf, unfNext;
  logic             step;
  logic             setOvf, setUnf;

  // Next-state logic: clear beats load beats a prescaled count step.
  always_comb begin
    qNext     = q;
    phaseNext = phase;
    tcNext    = 1'b0;
    step      = 1'b0;
    setOvf    = 1'b0;
    setUnf    = 1'b0;
    if (bus.clear) begin
      qNext     = '0;
      phaseNext = '0;
    end else if (bus.load) begin
      qNext     = (bus.load_val > MAXV) ? MAXV : bus.load_val;
      phaseNext = '0;
    end else if (bus.en) begin
      if (phase == PLAST) begin
        phaseNext = '0;
        step      = 1'b1;
      end else begin
        phaseNext = phase + PW'(1);
      end
      if (step) begin
        if (bus.up) begin
          if (q == MAXV) begin
            setOvf = 1'b1;
            tcNext = 1'b1;
            qNext  = (SATURATE != 0) ? MAXV : '0;
          end else begin
            qNext = q + WIDTH'(1);
          end
        end else begin
          if (q == '0) begin
            setUnf = 1'b1;
            tcNext = 1'b1;
            qNext  = (SATURATE != 0) ? '0 : MAXV;
          end else begin
            qNext = q - WIDTH'(1);
          end
        end
      end
    end
    // A boundary step in the same cycle as flag_clr leaves the flag set.
    ovfNext = setOvf | (ovf & ~bus.flag_clr);
    unfNext = setUnf | (unf & ~bus.flag_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q     <= '0;
      phase <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      q     <= qNext;
      phase <= phaseNext;
      tc    <= tcNext;
      ovf   <= ovfNext;
      unf   <= unfNext;
    end
  end

  assign bus.q   = q;
  assign bus.tc  = tc;
  assign bus.ovf = ovf;
  assign bus.unf = unf;

endmodule

// File: doc/prog_updown_counter.md
Name: prog_updown_counter

Overview:
- Parametrised synchronous up/down counter. It is the next generation of the team's ripple T-flip-flop counter.
- Adds programmable modulus, an enable prescaler, parallel load, a wrap or saturate mode, a terminal-count pulse, and sticky overflow/underflow flags.
- Used as a general event/timebase counter in timer and stimulus blocks.
- All state updates on the rising edge of clk. It has no ripple clocking.

Parameters:
- WIDTH, 4, counter width in bits; ≥1.
- MAX_COUNT, 15, terminal value; 1 ≤ MAX_COUNT ≤ 2^WIDTH−1. Count range is 0..MAX_COUNT.
- PRESCALE, 1, number of enabled cycles per count step; ≥1. A value of 1 means a step on every enabled cycle.
- SATURATE, 0, boundary mode. 0 = wrap, 1 = saturate (hold at boundary).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable; gates both the prescaler and the counter.
- up  input  1  direction: 1 = increment, 0 = decrement. Sampled at each step.
- clear  input  1  synchronous clear of the counter and prescaler.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  load value.
- flag_clr  input  1  synchronous clear of the ovf and unf flags.
- q  output  WIDTH  registered count.
- tc  output  1  registered one-cycle terminal-count pulse.
- ovf  output  1  sticky flag: an up step occurred at MAX_COUNT.
- unf  output  1  sticky flag: a down step occurred at 0.

Behaviour:
- Reset:
  - reset=1 forces q=0, tc=0, ovf=0, unf=0, and prescaler=0 immediately, with no clock edge needed.
  - These values hold while reset is high.
  - Counting resumes on the first rising clk edge after reset deasserts.
  - Deassertion mid-operation restarts from 0 with the prescaler phase at 0.
- Priority per clk edge: clear > load > count step.
- clear=1:
  - q←0 and prescaler←0.
  - tc←0; flags are unaffected.
- load=1 (and clear=0):
  - q←min(load_val, MAX_COUNT). Out-of-range values clamp to MAX_COUNT.
  - prescaler←0 and tc←0. No step occurs that cycle, even if en=1.
- Prescaler:
  - A counter of width max(1, clog2(PRESCALE)).
  - Increments only when en=1. When it equals PRESCALE−1 with en=1, it returns to 0 and asserts an internal step.
  - When PRESCALE=1, step = en.
  - en=0 freezes the prescaler phase; it does not reset it.
- Step, up=1:
  - If q<MAX_COUNT: q←q+1.
  - If q==MAX_COUNT: q←0 when SATURATE=0, or q held at MAX_COUNT when SATURATE=1. In both modes ovf←1 and tc←1.
- Step, up=0:
  - If q>0: q←q−1.
  - If q==0: q←MAX_COUNT when SATURATE=0, or q held at 0 when SATURATE=1. In both modes unf←1 and tc←1.
- tc:
  - Registered. High for exactly one cycle following each boundary step.
  - Low in every other cycle, including when saturation holds with no further step.
  - Consecutive boundary steps in saturate mode with PRESCALE=1 keep tc high on each of those cycles.
- Flags:
  - ovf and unf stay set until flag_clr or reset.
  - If flag_clr and a setting event occur in the same cycle, set wins (flag=1).
- Direction change takes effect on the next step. The prescaler phase is not disturbed.
- Arithmetic is WIDTH-bit. MAX_COUNT < 2^WIDTH−1 gives a true modulus (for example, a decade counter). A q value above MAX_COUNT is unreachable.

Test Plan:
- Reset mid-count:
  - Stimulus: WIDTH=4, defaults, en=1, up=1; count to q=7, then pulse reset for 3 ns between clock edges.
  - Response: q=0 and flags=0 immediately, before the next edge. After release, q=1 at the first edge.
- Decade wrap:
  - Stimulus: MAX_COUNT=9, SATURATE=0, en=1, up=1 for 12 cycles.
  - Response: q runs 1..9, 0, 1, 2. tc is high exactly one cycle, coincident with q=0. ovf=1 afterwards and stays set until flag_clr.
- Saturate down:
  - Stimulus: SATURATE=1, load 2, then up=0 for 5 cycles.
  - Response: q runs 1, 0, 0, 0, 0. tc is high on the three hold cycles. unf=1; ovf=0.
- Prescale and enable gating:
  - Stimulus: PRESCALE=3, en toggled 1,1,0,1,1,1,1.
  - Response: q increments only on the 3rd and 6th enabled cycles (q=1 then q=2). The en=0 cycle does not reset the phase.
- Priority and clamp:
  - Stimulus: MAX_COUNT=9; load=1 with load_val=13 and en=1. Next cycle, clear=1 and load=1 together.
  - Response: q=9 after the first edge, with no step. q=0 after the second edge.
- Flag race:
  - Stimulus: q=MAX_COUNT, en=1, up=1, flag_clr=1 in the same cycle.
  - Response: ovf=1. A later flag_clr alone gives ovf=0.
